ifm_linebuf_sched: RTL and testbench

//  Schedules IFM row loads into three rotating line buffers and serves the 3-row window to pe_engine.

---
 rtl/ifm_linebuf_sched_if.sv | 43 ++++
 rtl/ifm_linebuf_sched.sv | 165 ++++++++++++++++
 tb/tb_ifm_linebuf_sched.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifm_linebuf_sched_if.sv
// Bundle between cnn_ctrl/memory/pe_engine and the IFM line-buffer scheduler.
// slave = scheduler side, master = controller/memory/pe side.
interface ifm_linebuf_sched_if #(
  parameter int unsigned IFM_DW = 32,
  parameter int unsigned W_SIZE = 9,
  parameter int unsigned W_ADDR = 16
) ();
  logic              q_start;
  logic [W_SIZE-1:0] q_width;
  logic [W_SIZE-1:0] q_height;
  logic              c_req_load;
  logic [W_SIZE-1:0] c_req_row;
  logic              o_req_ready;
  logic              o_mem_rd_en;
  logic [W_ADDR-1:0] o_mem_rd_addr;
  logic              i_mem_rd_vld;
  logic [IFM_DW-1:0] i_mem_rd_data;
  logic              o_buf_done;
  logic              c_ctrl_data_run;
  logic [W_SIZE-1:0] c_row;
  logic [W_SIZE-1:0] c_col;
  logic [IFM_DW-1:0] o_ifm_data0;
  logic [IFM_DW-1:0] o_ifm_data1;
  logic [IFM_DW-1:0] o_ifm_data2;
  logic              o_ifm_miss;
  logic              o_err;
  logic [15:0]       o_stat_loads;
  logic [15:0]       o_stat_miss;

  modport slave (
    input  q_start, q_width, q_height, c_req_load, c_req_row, i_mem_rd_vld, i_mem_rd_data,
           c_ctrl_data_run, c_row, c_col,
    output o_req_ready, o_mem_rd_en, o_mem_rd_addr, o_buf_done, o_ifm_data0, o_ifm_data1,
           o_ifm_data2, o_ifm_miss, o_err, o_stat_loads, o_stat_miss
  );

  modport master (
    output q_start, q_width, q_height, c_req_load, c_req_row, i_mem_rd_vld, i_mem_rd_data,
           c_ctrl_data_run, c_row, c_col,
    input  o_req_ready, o_mem_rd_en, o_mem_rd_addr, o_buf_done, o_ifm_data0, o_ifm_data1,
           o_ifm_data2, o_ifm_miss, o_err, o_stat_loads, o_stat_miss
  );
endinterface

// File: rtl/ifm_linebuf_sched.sv
// Three rotating IFM line buffers: loads rows from memory and serves the r-1/r/r+1 window.
// Optional IFM_SCHED_STATS_EN adds saturating load/miss counters (ports tied 0 otherwise).
module ifm_linebuf_sched #(
  parameter int unsigned IFM_DW = 32,
  parameter int unsigned W_SIZE = 9,
  parameter int unsigned W_ADDR = 16
) (
  input logic                clk,
  input logic                rst,
  ifm_linebuf_sched_if.slave bus
);
  localparam int unsigned Depth = 1 << W_SIZE;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic              clr;
  logic [1:0]        slot_ptr_q;
  logic [W_SIZE-1:0] icol_q, wcol_q, row_q, exp_row_q;
  logic [W_ADDR-1:0] base_q;
  logic [2:0]        tag_vld_q;
  logic [W_SIZE-1:0] tag_row_q [3];
  logic              err_q;
  logic [IFM_DW-1:0] lbuf_q [3][Depth];
  logic [IFM_DW-1:0] win_q [3];
  logic [IFM_DW-1:0] win_d [3];
  logic              miss_q, miss_d;
  logic [W_SIZE-1:0] want_row [3];
  logic [2:0]        pad, hit;
  logic [W_SIZE-1:0] last_col;
  logic              slot_free, accept, wr_en, done, req_ready, rd_en;

  assign clr      = rst | bus.q_start;
  assign last_col = bus.q_width - W_SIZE'(1);
  // The target slot may be recycled once its row is older than the window's top row.
  assign slot_free = ~tag_vld_q[slot_ptr_q] |
                     (({1'b0, tag_row_q[slot_ptr_q]} + (W_SIZE+1)'(1)) < {1'b0, bus.c_row});
  assign wr_en = bus.i_mem_rd_vld & ~clr & ((state_q == StIssue) | (state_q == StDrain));

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    done      = 1'b0;
    req_ready = 1'b0;
    rd_en     = 1'b0;
    case (state_q)
      StIdle: begin
        req_ready = slot_free & ~clr;
        accept    = bus.c_req_load & slot_free & ~clr;
        if (accept) state_d = StIssue;
      end
      StIssue: begin
        rd_en = ~clr;
        if (icol_q == last_col) state_d = StDrain;
      end
      StDrain: if (wr_en && (wcol_q == last_col)) state_d = StDone;
      StDone: begin
        done    = ~clr;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (clr) state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= StIdle;
      slot_ptr_q <= '0;
      icol_q     <= '0;
      wcol_q     <= '0;
      row_q      <= '0;
      exp_row_q  <= '0;
      base_q     <= '0;
      tag_vld_q  <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < 3; i++) tag_row_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIssue) icol_q <= icol_q + W_SIZE'(1);
      if (wr_en) wcol_q <= wcol_q + W_SIZE'(1);
      if (accept) begin
        row_q  <= bus.c_req_row;
        icol_q <= '0;
        wcol_q <= '0;
        if (bus.c_req_row != exp_row_q) err_q <= 1'b1;
      end
      if (done) begin
        tag_vld_q[slot_ptr_q] <= 1'b1;
        tag_row_q[slot_ptr_q] <= row_q;
        slot_ptr_q            <= (slot_ptr_q == 2'd2) ? 2'd0 : slot_ptr_q + 2'd1;
        base_q                <= base_q + W_ADDR'(bus.q_width);
        exp_row_q             <= exp_row_q + W_SIZE'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) lbuf_q[slot_ptr_q][wcol_q] <= bus.i_mem_rd_data;
  end

  // Window lookup by tag; padded edges read as zero and never count as a miss.
  always_comb begin
    want_row[0] = bus.c_row - W_SIZE'(1);
    want_row[1] = bus.c_row;
    want_row[2] = bus.c_row + W_SIZE'(1);
    pad[0]      = (bus.c_row == '0);
    pad[1]      = 1'b0;
    pad[2]      = (bus.c_row == (bus.q_height - W_SIZE'(1)));
    hit         = '0;
    miss_d      = 1'b0;
    for (int k = 0; k < 3; k++) begin
      win_d[k] = '0;
      for (int i = 0; i < 3; i++) begin
        if (!pad[k] && tag_vld_q[i] && (tag_row_q[i] == want_row[k])) begin
          hit[k]   = 1'b1;
          win_d[k] = lbuf_q[i][bus.c_col];
        end
      end
      if (!pad[k] && !hit[k]) miss_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < 3; k++) win_q[k] <= '0;
      miss_q <= 1'b0;
    end else if (bus.c_ctrl_data_run) begin
      for (int k = 0; k < 3; k++) win_q[k] <= win_d[k];
      miss_q <= miss_d;
    end else begin
      miss_q <= 1'b0;
    end
  end

  assign bus.o_req_ready   = req_ready;
  assign bus.o_mem_rd_en   = rd_en;
  assign bus.o_mem_rd_addr = base_q + W_ADDR'(icol_q);
  assign bus.o_buf_done    = done;
  assign bus.o_ifm_data0   = win_q[0];
  assign bus.o_ifm_data1   = win_q[1];
  assign bus.o_ifm_data2   = win_q[2];
  assign bus.o_ifm_miss    = miss_q;
  assign bus.o_err         = err_q;

`ifdef IFM_SCHED_STATS_EN
  logic [15:0] stat_loads_q, stat_miss_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      stat_loads_q <= '0;
      stat_miss_q  <= '0;
    end else begin
      if (done && (stat_loads_q != '1)) stat_loads_q <= stat_loads_q + 16'd1;
      if (miss_q && (stat_miss_q != '1)) stat_miss_q <= stat_miss_q + 16'd1;
    end
  end

  assign bus.o_stat_loads = stat_loads_q;
  assign bus.o_stat_miss  = stat_miss_q;
`else
  assign bus.o_stat_loads = '0;
  assign bus.o_stat_miss  = '0;
`endif
endmodule

// File: tb/tb_ifm_linebuf_sched.sv
// Scoreboard bench for ifm_linebuf_sched: queue-based reference of resident rows,
// memory responder with configurable latency, monitor comparing reads/done/window.
module tb_ifm_linebuf_sched;
  localparam int IFM_DW = 32;
  localparam int W_SIZE = 9;
  localparam int W_ADDR = 16;

  typedef struct packed {
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        miss;
  } win_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifm_linebuf_sched_if #(.IFM_DW(IFM_DW), .W_SIZE(W_SIZE), .W_ADDR(W_ADDR)) bus ();
  ifm_linebuf_sched #(.IFM_DW(IFM_DW), .W_SIZE(W_SIZE), .W_ADDR(W_ADDR)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 2;
  int w = 16;
  int h = 3;
  logic [31:0] seed;
  bit mon_on = 1'b0;

  // reference state
  int ld_row[$];
  int ld_base[$];
  int base_m = 0;
  int exp_row_m = 0;
  bit err_m = 1'b0;
  int loads_m = 0;
  int miss_m = 0;

  // scoreboard queues
  logic [W_ADDR-1:0] addr_q[$];
  int done_q[$];
  win_t win_exp_q[$];
  win_t last_win = '0;
  win_t mon_e;
  int done_cnt = 0;
  logic run_seen = 1'b0;
  logic clr_seen = 1'b0;

  function automatic logic [31:0] memfn(input logic [W_ADDR-1:0] a, input logic [31:0] s);
    return (32'(a) * 32'h9E3779B1) ^ s;
  endfunction

  // memory responder: read issued at edge k is presented for sampling at edge k+lat
  logic [3:0] p_vld;
  logic [W_ADDR-1:0] p_addr[4];
  always @(posedge clk) begin
    if (rst) p_vld <= '0;
    else p_vld <= {p_vld[2:0], bus.o_mem_rd_en};
    p_addr[0] <= bus.o_mem_rd_addr;
    for (int i = 1; i < 4; i++) p_addr[i] <= p_addr[i-1];
  end
  assign bus.i_mem_rd_vld  = p_vld[lat-1];
  assign bus.i_mem_rd_data = memfn(p_addr[lat-1], seed);

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    run_seen <= bus.c_ctrl_data_run;
    clr_seen <= rst | bus.q_start;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit ready_m(input int cr);
    int n = ld_row.size();
    if (n < 3) return 1'b1;
    return (ld_row[n-3] + 1) < cr;
  endfunction

  function automatic logic [31:0] lookup(input int rr, input int c, output bit found);
    int n = ld_row.size();
    found = 1'b0;
    lookup = '0;
    for (int j = (n > 3 ? n - 3 : 0); j < n; j++) begin
      if (ld_row[j] == rr) begin
        found = 1'b1;
        lookup = memfn(W_ADDR'(ld_base[j] + c), seed);
      end
    end
  endfunction

  function automatic win_t model_win(input int r, input int c);
    win_t e;
    bit f;
    e = '0;
    e.d1 = lookup(r, c, f);
    if (!f) e.miss = 1'b1;
    if (r != 0) begin
      e.d0 = lookup(r - 1, c, f);
      if (!f) e.miss = 1'b1;
    end
    if (r != h - 1) begin
      e.d2 = lookup(r + 1, c, f);
      if (!f) e.miss = 1'b1;
    end
    return e;
  endfunction

  // monitor: compares whatever the DUT presents against the scoreboard queues
  always @(negedge clk) begin
    if (mon_on) begin
      if (bus.o_mem_rd_en === 1'b1 && !bus.q_start && !rst) begin
        if (addr_q.size() == 0) begin
          errors++;
          $display("FAIL rd_addr: unexpected read at %0h, none expected", bus.o_mem_rd_addr);
        end else begin
          chk("rd_addr", 64'(bus.o_mem_rd_addr), 64'(addr_q.pop_front()));
        end
      end
      if (bus.o_buf_done === 1'b1) begin
        done_cnt++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL buf_done: unexpected pulse at cycle %0d, none expected", cyc);
        end else begin
          chk("buf_done_cycle", 64'(cyc), 64'(done_q.pop_front()));
        end
      end
      if (clr_seen) begin
        last_win = '0;
        chk("clr_data0", 64'(bus.o_ifm_data0), 64'(0));
        chk("clr_data1", 64'(bus.o_ifm_data1), 64'(0));
        chk("clr_data2", 64'(bus.o_ifm_data2), 64'(0));
        chk("clr_miss", 64'(bus.o_ifm_miss), 64'(0));
      end else if (run_seen) begin
        if (win_exp_q.size() == 0) begin
          errors++;
          $display("FAIL window: got output with no expectation queued");
        end else begin
          mon_e = win_exp_q.pop_front();
          chk("win_data0", 64'(bus.o_ifm_data0), 64'(mon_e.d0));
          chk("win_data1", 64'(bus.o_ifm_data1), 64'(mon_e.d1));
          chk("win_data2", 64'(bus.o_ifm_data2), 64'(mon_e.d2));
          chk("win_miss", 64'(bus.o_ifm_miss), 64'(mon_e.miss));
          last_win = mon_e;
        end
      end else begin
        chk("hold_data0", 64'(bus.o_ifm_data0), 64'(last_win.d0));
        chk("hold_data1", 64'(bus.o_ifm_data1), 64'(last_win.d1));
        chk("hold_data2", 64'(bus.o_ifm_data2), 64'(last_win.d2));
        chk("hold_miss", 64'(bus.o_ifm_miss), 64'(0));
      end
    end
  end

  task automatic do_qstart(input int nw, input int nh);
    bus.q_width = W_SIZE'(nw);
    bus.q_height = W_SIZE'(nh);
    bus.q_start = 1'b1;
    addr_q.delete();
    done_q.delete();
    ld_row.delete();
    ld_base.delete();
    base_m = 0;
    exp_row_m = 0;
    err_m = 1'b0;
    loads_m = 0;
    miss_m = 0;
    w = nw;
    h = nh;
    tick();
    bus.q_start = 1'b0;
  endtask

  // block_row < 0 skips the "slot not free yet" probe
  task automatic load_row(input int row, input int block_row, input int run_row);
    int target;
    bus.c_req_load = 1'b1;
    bus.c_req_row = W_SIZE'(row);
    if (block_row >= 0) begin
      bus.c_row = W_SIZE'(block_row);
      #1;
      chk("req_ready_blocked", 64'(bus.o_req_ready), 64'(ready_m(block_row)));
      tick();
    end
    bus.c_row = W_SIZE'(run_row);
    #1;
    chk("req_ready", 64'(bus.o_req_ready), 64'(ready_m(run_row)));
    if (bus.o_req_ready !== 1'b1) begin
      bus.c_req_load = 1'b0;
      return;
    end
    for (int i = 0; i < w; i++) addr_q.push_back(W_ADDR'(base_m + i));
    if (row != exp_row_m) err_m = 1'b1;
    target = done_cnt + 1;
    tick();
    bus.c_req_load = 1'b0;
    done_q.push_back(cyc + w + lat);
    for (int i = 0; i < w + lat + 20 && done_cnt < target; i++) tick();
    if (done_cnt < target) begin
      errors++;
      $display("FAIL buf_done_timeout: got no pulse for row %0d, required one", row);
      addr_q.delete();
      done_q.delete();
    end
    ld_row.push_back(row);
    ld_base.push_back(base_m);
    base_m = (base_m + w) % 65536;
    exp_row_m++;
    loads_m++;
    chk("err_flag", 64'(bus.o_err), 64'(err_m));
  endtask

  task automatic win_check(input int r, input int c);
    win_t e;
    bus.c_row = W_SIZE'(r);
    bus.c_col = W_SIZE'(c);
    bus.c_ctrl_data_run = 1'b1;
    e = model_win(r, c);
    if (e.miss) miss_m++;
    win_exp_q.push_back(e);
    tick();
    bus.c_ctrl_data_run = 1'b0;
  endtask

  task automatic chk_stats();
    tick();
    tick();
`ifdef IFM_SCHED_STATS_EN
    chk("stat_loads", 64'(bus.o_stat_loads), 64'(loads_m));
    chk("stat_miss", 64'(bus.o_stat_miss), 64'(miss_m));
`else
    chk("stat_loads", 64'(bus.o_stat_loads), 64'(0));
    chk("stat_miss", 64'(bus.o_stat_miss), 64'(0));
`endif
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no end of stimulus, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw, nh, cr;
    seed = $urandom;
    rst = 1'b1;
    bus.q_start = 1'b0;
    bus.q_width = 16;
    bus.q_height = 3;
    bus.c_req_load = 1'b0;
    bus.c_req_row = '0;
    bus.c_ctrl_data_run = 1'b0;
    bus.c_row = '0;
    bus.c_col = '0;
    tick();
    tick();
    mon_on = 1'b1;
    chk("rst_ready", 64'(bus.o_req_ready), 64'(0));
    chk("rst_rd_en", 64'(bus.o_mem_rd_en), 64'(0));
    chk("rst_done", 64'(bus.o_buf_done), 64'(0));
    chk("rst_err", 64'(bus.o_err), 64'(0));
    tick();
    rst = 1'b0;
    #1;
    chk("idle_ready", 64'(bus.o_req_ready), 64'(1));

    // rows 0,1 then window with row 2 absent
    load_row(0, -1, 0);
    load_row(1, -1, 0);
    win_check(0, 3);
    win_check(1, 9);
    load_row(2, -1, 0);
    win_check(1, 5);
    win_check(0, 0);
    win_check(2, 15);
    tick();
    // row 3 waits until c_row moves past row 0's window use
    load_row(3, 1, 2);
    win_check(2, 7);
    chk_stats();

    // out-of-order request sets sticky error; q_start clears it and the tags
    do_qstart(16, 3);
    load_row(0, -1, 0);
    load_row(2, -1, 0);
    tick();
    chk("err_sticky", 64'(bus.o_err), 64'(1));
    do_qstart(16, 3);
    #1;
    chk("err_cleared", 64'(bus.o_err), 64'(0));
    win_check(0, 4);

    // abort a load at icol=7, let stale data drain, then reload row 0 from address 0
    bus.c_row = '0;
    bus.c_req_load = 1'b1;
    bus.c_req_row = '0;
    #1;
    chk("abort_ready", 64'(bus.o_req_ready), 64'(1));
    for (int i = 0; i < 7; i++) addr_q.push_back(W_ADDR'(i));
    tick();
    bus.c_req_load = 1'b0;
    repeat (7) tick();
    do_qstart(16, 3);
    #1;
    chk("abort_idle_ready", 64'(bus.o_req_ready), 64'(1));
    repeat (6) tick();
    load_row(0, -1, 0);
    win_check(0, 11);
    chk_stats();

    // randomized frames
    for (int p = 0; p < 4; p++) begin
      nw = int'($urandom_range(2, 24));
      nh = int'($urandom_range(3, 7));
      lat = int'($urandom_range(1, 4));
      do_qstart(nw, nh);
      for (int r = 0; r < nh; r++) begin
        cr = (r >= 1) ? r - 1 : 0;
        load_row(r, (r >= 3) ? r - 2 : -1, cr);
        win_check(cr, int'($urandom_range(0, nw - 1)));
        win_check(cr, int'($urandom_range(0, nw - 1)));
        win_check(r, int'($urandom_range(0, nw - 1)));
      end
      chk_stats();
    end

    repeat (6) tick();
    chk("addr_queue_empty", 64'(addr_q.size()), 64'(0));
    chk("done_queue_empty", 64'(done_q.size()), 64'(0));
    chk("win_queue_empty", 64'(win_exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
